inner_product_dispatcher: RTL and testbench

//  Initiator side of the inner_product stb/ack protocol. Snapshots matrices A (ROWS x INNER)
//  and B (INNER x COLS) of 32-bit float words on start. Presents every row/column pair to one

---
 rtl/inner_product_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_inner_product_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inner_product_dispatcher.sv
// Initiator for the inner_product stb/ack protocol: walks every (row, column) pair of the
// snapshotted A and B through one responder and gathers the scalar results into C.
module inner_product_dispatcher #(
  parameter int ROWS    = 2,
  parameter int INNER   = 4,
  parameter int COLS    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [32*ROWS*INNER-1:0]   matrix_a,
  input  logic [32*INNER*COLS-1:0]   matrix_b,
  output logic [32*INNER-1:0]        row_o,
  output logic [32*INNER-1:0]        column_o,
  output logic                       row_o_stb,
  output logic                       column_o_stb,
  input  logic                       row_i_ack,
  input  logic                       column_i_ack,
  input  logic [31:0]                res_i,
  input  logic                       res_i_stb,
  output logic                       res_o_ack,
  output logic [32*ROWS*COLS-1:0]    result,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, DRAIN, FINISH} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   i_reg;
  logic [JW-1:0]   j_reg;
  logic            row_ack_reg, col_ack_reg;
  logic [TW-1:0]   timer_reg;
  logic            error_reg;
  logic [31:0]     a_mem [ROWS][INNER];
  logic [31:0]     b_mem [INNER][COLS];
  logic [31:0]     c_mem [ROWS][COLS];

  logic accept, capture, advance, abort;
  logic both_acked, last_pair, timeout_hit;

  // An ack seen in an earlier cycle counts just like one arriving now.
  assign both_acked  = (row_ack_reg | row_i_ack) & (col_ack_reg | column_i_ack);
  assign last_pair   = (i_reg == IW'(ROWS - 1)) && (j_reg == JW'(COLS - 1));
  assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));
  assign error       = error_reg;

  always_comb begin
    state_next   = state_reg;
    row_o_stb    = 1'b0;
    column_o_stb = 1'b0;
    res_o_ack    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    abort        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        row_o_stb    = 1'b1;
        column_o_stb = 1'b1;
        res_o_ack    = 1'b1;
        busy         = 1'b1;
        if (both_acked) begin
          state_next = WAIT_RES;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = FINISH;
        end
      end
      WAIT_RES: begin
        res_o_ack = 1'b1;
        busy      = 1'b1;
        if (res_i_stb) begin
          capture    = 1'b1;
          state_next = DRAIN;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = FINISH;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Hold off until the responder releases its strobe so it is not captured twice.
        if (!res_i_stb) begin
          if (last_pair) begin
            state_next = FINISH;
          end else begin
            advance    = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_reg       <= '0;
      j_reg       <= '0;
      row_ack_reg <= 1'b0;
      col_ack_reg <= 1'b0;
      timer_reg   <= '0;
      error_reg   <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < INNER; k++) a_mem[r][k] <= '0;
      for (int k = 0; k < INNER; k++)
        for (int c = 0; c < COLS; c++) b_mem[k][c] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) c_mem[r][c] <= '0;
    end else begin
      if (accept) begin
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < INNER; k++) a_mem[r][k] <= matrix_a[32*(r*INNER+k) +: 32];
        for (int k = 0; k < INNER; k++)
          for (int c = 0; c < COLS; c++) b_mem[k][c] <= matrix_b[32*(k*COLS+c) +: 32];
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) c_mem[r][c] <= '0;
        i_reg     <= '0;
        j_reg     <= '0;
        error_reg <= 1'b0;
      end
      if (abort) error_reg <= 1'b1;

      if (capture) c_mem[i_reg][j_reg] <= res_i;

      if (advance) begin
        if (j_reg == JW'(COLS - 1)) begin
          j_reg <= '0;
          i_reg <= i_reg + IW'(1);
        end else begin
          j_reg <= j_reg + JW'(1);
        end
      end

      if (state_reg == ISSUE && state_next == ISSUE) begin
        row_ack_reg <= row_ack_reg | row_i_ack;
        col_ack_reg <= col_ack_reg | column_i_ack;
      end else begin
        row_ack_reg <= 1'b0;
        col_ack_reg <= 1'b0;
      end

      // Watchdog restarts whenever a new state is entered.
      if (state_next != state_reg)
        timer_reg <= '0;
      else if (state_reg == ISSUE || state_reg == WAIT_RES)
        timer_reg <= timer_reg + TW'(1);
    end
  end

  for (genvar gi = 0; gi < INNER; gi++) begin : g_lane
    assign row_o[32*gi +: 32]    = a_mem[i_reg][gi];
    assign column_o[32*gi +: 32] = b_mem[gi][j_reg];
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_res_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_res_col
      assign result[32*(gi*COLS+gj) +: 32] = c_mem[gi][gj];
    end
  end

endmodule

// File: tb/tb_inner_product_dispatcher.sv
// Randomized bench: a behavioural inner_product responder plus a matrix-level float model of C.
module tb_inner_product_dispatcher;

  localparam int ROWS = 2;
  localparam int INNER = 4;
  localparam int COLS = 2;
  localparam int TB_TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [32*ROWS*INNER-1:0] matrix_a;
  logic [32*INNER*COLS-1:0] matrix_b;
  logic [32*INNER-1:0]      row_o, column_o;
  logic                     row_o_stb, column_o_stb;
  logic                     row_i_ack, column_i_ack;
  logic [31:0]              res_i;
  logic                     res_i_stb;
  logic                     res_o_ack;
  logic [32*ROWS*COLS-1:0]  result;
  logic                     busy, done, error;

  inner_product_dispatcher #(
    .ROWS(ROWS), .INNER(INNER), .COLS(COLS), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .row_o(row_o), .column_o(column_o),
    .row_o_stb(row_o_stb), .column_o_stb(column_o_stb),
    .row_i_ack(row_i_ack), .column_i_ack(column_i_ack),
    .res_i(res_i), .res_i_stb(res_i_stb), .res_o_ack(res_o_ack),
    .result(result), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // IEEE single <-> real, exact for the small integer values used here.
  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else begin
      e = {3'b000, x[30:23]} + 11'd896;
      d = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] dot(input logic [32*INNER-1:0] r, input logic [32*INNER-1:0] c);
    real acc = 0.0;
    for (int k = 0; k < INNER; k++) acc += f2r(r[32*k +: 32]) * f2r(c[32*k +: 32]);
    return r2f(acc);
  endfunction

  // Reference matrices
  logic [31:0] a_m [ROWS][INNER];
  logic [31:0] b_m [INNER][COLS];

  function automatic logic [31:0] model_c(input int i, input int j);
    real acc = 0.0;
    for (int k = 0; k < INNER; k++) acc += f2r(a_m[i][k]) * f2r(b_m[k][j]);
    return r2f(acc);
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < INNER; k++) matrix_a[32*(i*INNER+k) +: 32] = a_m[i][k];
    for (int k = 0; k < INNER; k++)
      for (int j = 0; j < COLS; j++) matrix_b[32*(k*COLS+j) +: 32] = b_m[k][j];
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < INNER; k++) a_m[i][k] = r2f(real'($urandom_range(1, 7)));
    for (int k = 0; k < INNER; k++)
      for (int j = 0; j < COLS; j++) b_m[k][j] = r2f(real'($urandom_range(1, 7)));
  endtask

  // Responder model configuration and observations
  int  row_delay = 0, col_delay = 0, res_delay = 0, hold_len = 1;
  bit  never_ack = 1'b0;
  int  ack_pairs = 0;
  int  early_drop = 0;
  int  done_cnt = 0;
  logic [32*INNER-1:0] row_log [$];
  logic [32*INNER-1:0] col_log [$];

  initial begin
    int  r_cnt, c_cnt, res_cnt, hold_cnt;
    bit  r_done, c_done, res_active, prev_stb;
    logic [32*INNER-1:0] row_cap, col_cap;
    row_i_ack = 1'b0; column_i_ack = 1'b0; res_i_stb = 1'b0; res_i = '0;
    r_cnt = 0; c_cnt = 0; res_cnt = 0; hold_cnt = 0;
    r_done = 0; c_done = 0; res_active = 0; prev_stb = 0;
    row_cap = '0; col_cap = '0;
    forever begin
      @(posedge clk);
      #1;
      row_i_ack = 1'b0;
      column_i_ack = 1'b0;
      if (rst !== 1'b1) begin
        res_i_stb = 1'b0;
        r_cnt = 0; c_cnt = 0; res_cnt = 0; hold_cnt = 0;
        r_done = 0; c_done = 0; res_active = 0; prev_stb = 0;
        continue;
      end
      if (prev_stb && !row_o_stb && !(r_done && c_done) && !never_ack) early_drop++;
      prev_stb = row_o_stb;
      if (row_o_stb && !r_done && !never_ack) begin
        if (r_cnt >= row_delay) begin
          row_i_ack = 1'b1; r_done = 1; row_cap = row_o;
          if (c_done) ack_pairs++;
        end else r_cnt++;
      end
      if (column_o_stb && !c_done && !never_ack) begin
        if (c_cnt >= col_delay) begin
          column_i_ack = 1'b1; c_done = 1; col_cap = column_o;
          if (r_done) ack_pairs++;
        end else c_cnt++;
      end
      if (res_active) begin
        hold_cnt++;
        if (hold_cnt >= hold_len) begin
          res_i_stb = 1'b0; res_active = 0;
          r_done = 0; c_done = 0; r_cnt = 0; c_cnt = 0; res_cnt = 0;
        end
      end else if (r_done && c_done && !row_o_stb && !column_o_stb) begin
        if (res_cnt >= res_delay) begin
          res_i = dot(row_cap, col_cap);
          res_i_stb = 1'b1; res_active = 1; hold_cnt = 0;
          row_log.push_back(row_cap);
          col_log.push_back(col_cap);
        end else res_cnt++;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic run_mult(input string name, input bit restart_mid, input bit expect_timeout);
    int cyc, stb_cycles, overlap;
    bit finished;
    logic [32*INNER-1:0] exp_row, exp_col;
    row_log.delete();
    col_log.delete();
    early_drop = 0;
    ack_pairs = 0;
    pack_inputs();
    @(negedge clk);
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_on_start"}, busy, 1);
    cyc = 0; stb_cycles = 0; overlap = 0; finished = 0;
    while (!finished && cyc < 3000) begin
      if (row_o_stb) stb_cycles++;
      if (row_o_stb && res_i_stb) overlap++;
      if (done) finished = 1;
      else begin
        if (restart_mid && cyc == 6) begin
          for (int w = 0; w < ROWS*INNER; w++) matrix_a[32*w +: 32] = $urandom;
          start = 1'b1;
        end
        if (restart_mid && cyc == 7) start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_done_seen"}, finished, 1);
    repeat (4) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_error"}, error, expect_timeout);
    check({name, "_stb_res_overlap"}, overlap, 0);
    check({name, "_early_stb_drop"}, early_drop, 0);
    if (expect_timeout) begin
      check({name, "_issue_cycles"}, stb_cycles, TB_TIMEOUT);
      check({name, "_handshakes"}, row_log.size(), 0);
      check({name, "_result_zero"}, result, 0);
    end else begin
      check({name, "_handshakes"}, row_log.size(), ROWS*COLS);
      for (int p = 0; p < ROWS*COLS && p < row_log.size(); p++) begin
        for (int k = 0; k < INNER; k++) begin
          exp_row[32*k +: 32] = a_m[p / COLS][k];
          exp_col[32*k +: 32] = b_m[k][p % COLS];
        end
        check($sformatf("%s_row_pair%0d", name, p), row_log[p], exp_row);
        check($sformatf("%s_col_pair%0d", name, p), col_log[p], exp_col);
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          check($sformatf("%s_c%0d%0d", name, i, j), result[32*(i*COLS+j) +: 32], model_c(i, j));
    end
    $display("run %s: %0d handshakes, %0d cycles, error=%0b", name, row_log.size(), cyc, error);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; matrix_a = '0; matrix_b = '0;
    repeat (3) @(negedge clk);
    check("reset_row_o", row_o, 0);
    check("reset_column_o", column_o, 0);
    check("reset_result", result, 0);
    check("reset_ctrl", {row_o_stb, column_o_stb, res_o_ack, busy, done, error}, 0);
    rst = 1'b1;

    // Identity rows against all-2.0 columns
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < INNER; k++) a_m[i][k] = (i == k) ? 32'h3F800000 : 32'h0;
    for (int k = 0; k < INNER; k++)
      for (int j = 0; j < COLS; j++) b_m[k][j] = 32'h40000000;
    run_mult("identity", 0, 0);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        check($sformatf("identity_two_c%0d%0d", i, j), result[32*(i*COLS+j) +: 32], 32'h40000000);

    randomize_mats(); col_delay = 3;
    run_mult("ack_skew", 0, 0);
    col_delay = 0;

    randomize_mats(); hold_len = 5;
    run_mult("res_hold", 0, 0);
    hold_len = 1;

    randomize_mats();
    run_mult("restart_ignored", 1, 0);

    for (int n = 0; n < 4; n++) begin
      row_delay = $urandom_range(0, 4); col_delay = $urandom_range(0, 4);
      res_delay = $urandom_range(0, 4); hold_len = $urandom_range(1, 3);
      randomize_mats();
      run_mult($sformatf("random%0d", n), 0, 0);
    end
    row_delay = 0; col_delay = 0; res_delay = 0; hold_len = 1;

    never_ack = 1'b1;
    run_mult("timeout", 0, 1);
    never_ack = 1'b0;
    randomize_mats();
    run_mult("post_timeout", 0, 0);

    // Reset while waiting on the result of pair (1,0)
    randomize_mats(); res_delay = 10;
    pack_inputs();
    ack_pairs = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(ack_pairs >= 3 && !row_o_stb) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset_reached_pair10", ack_pairs, 3);
    rst = 1'b0;
    #1;
    check("midreset_result", result, 0);
    check("midreset_row_o", row_o, 0);
    check("midreset_column_o", column_o, 0);
    check("midreset_ctrl", {row_o_stb, column_o_stb, res_o_ack, busy, done, error}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    res_delay = 1;
    randomize_mats();
    run_mult("after_reset", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
